// File: rtl/mem_lsu_stage.sv
// Load/store stage between EX and MEM/WB. It issues one 8-byte-aligned memory request per
// memory op, formats store data/masks and load results, and flags misaligned accesses.
module mem_lsu_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_inst,
    input  logic [4:0]  in_rd,
    input  logic        in_rd_w_en,
    input  logic [63:0] in_exu_result,
    input  logic [63:0] in_x_rs2,
    input  logic        in_mem_r_en,
    input  logic        in_mem_w_en,
    input  logic [2:0]  in_funct3,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    output logic        mem_req_wen,
    output logic [63:0] mem_req_wdata,
    output logic [7:0]  mem_req_wmask,
    input  logic        mem_resp_valid,
    input  logic [63:0] mem_resp_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic [4:0]  out_rd,
    output logic        out_rd_w_en,
    output logic [63:0] out_exu_result,
    output logic [63:0] out_lsu_r_data,
    output logic        out_misalign
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_e;

    // Low address bits that must be zero for an access of size 2**sz bytes.
    function automatic logic [2:0] align_mask(input logic [1:0] sz);
        case (sz)
            2'd0:    align_mask = 3'b000;
            2'd1:    align_mask = 3'b001;
            2'd2:    align_mask = 3'b011;
            2'd3:    align_mask = 3'b111;
            default: align_mask = 3'b111;
        endcase
    endfunction

    function automatic logic [7:0] byte_mask(input logic [1:0] sz);
        case (sz)
            2'd0:    byte_mask = 8'h01;
            2'd1:    byte_mask = 8'h03;
            2'd2:    byte_mask = 8'h0F;
            2'd3:    byte_mask = 8'hFF;
            default: byte_mask = 8'hFF;
        endcase
    endfunction

    // Shift the addressed bytes down to bit 0, then sign/zero extend; funct3 111 behaves as LD.
    function automatic logic [63:0] load_ext(input logic [63:0] rdata, input logic [2:0] off,
                                             input logic [2:0] f3);
        logic [63:0] sh;
        sh = rdata >> {off, 3'b000};
        case (f3)
            3'b000:  load_ext = {{56{sh[7]}}, sh[7:0]};
            3'b001:  load_ext = {{48{sh[15]}}, sh[15:0]};
            3'b010:  load_ext = {{32{sh[31]}}, sh[31:0]};
            3'b100:  load_ext = {56'd0, sh[7:0]};
            3'b101:  load_ext = {48'd0, sh[15:0]};
            3'b110:  load_ext = {32'd0, sh[31:0]};
            default: load_ext = sh;
        endcase
    endfunction

    state_e      state_q, state_d;
    logic [2:0]  f3_q, f3_d;
    logic        store_q, store_d;
    logic        req_valid_q, req_valid_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic        req_wen_q, req_wen_d;
    logic [63:0] req_wdata_q, req_wdata_d;
    logic [7:0]  req_wmask_q, req_wmask_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] out_inst_q, out_inst_d;
    logic [4:0]  out_rd_q, out_rd_d;
    logic        out_rd_w_en_q, out_rd_w_en_d;
    logic [63:0] out_exu_q, out_exu_d;
    logic [63:0] out_lsu_q, out_lsu_d;
    logic        out_mis_q, out_mis_d;

    logic        accept_s;
    logic        is_mem_s;
    logic        mis_s;
    logic [2:0]  off_s;

    assign in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready);
    assign accept_s = in_valid && in_ready;
    assign is_mem_s = in_mem_r_en || in_mem_w_en;
    assign off_s    = in_exu_result[2:0];
    assign mis_s    = |(off_s & align_mask(in_funct3[1:0]));

    // Next-state logic for the FSM, the request register and the output register.
    always_comb begin
        state_d       = state_q;
        f3_d          = f3_q;
        store_d       = store_q;
        req_valid_d   = req_valid_q;
        req_addr_d    = req_addr_q;
        req_wen_d     = req_wen_q;
        req_wdata_d   = req_wdata_q;
        req_wmask_d   = req_wmask_q;
        out_pc_d      = out_pc_q;
        out_inst_d    = out_inst_q;
        out_rd_d      = out_rd_q;
        out_rd_w_en_d = out_rd_w_en_q;
        out_exu_d     = out_exu_q;
        out_lsu_d     = out_lsu_q;
        out_mis_d     = out_mis_q;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    // The output slot is free at accept, so it doubles as the capture register.
                    out_pc_d   = in_pc;
                    out_inst_d = in_inst;
                    out_rd_d   = in_rd;
                    out_exu_d  = in_exu_result;
                    out_lsu_d  = 64'd0;
                    f3_d       = in_funct3;
                    store_d    = in_mem_w_en;
                    if (is_mem_s && !mis_s) begin
                        state_d       = S_REQ;
                        out_rd_w_en_d = in_rd_w_en;
                        out_mis_d     = 1'b0;
                        req_valid_d   = 1'b1;
                        req_addr_d    = {in_exu_result[31:3], 3'b000};
                        req_wen_d     = in_mem_w_en;
                        req_wdata_d   = in_x_rs2 << {off_s, 3'b000};
                        req_wmask_d   = byte_mask(in_funct3[1:0]) << off_s;
                    end else begin
                        state_d       = S_IDLE;
                        out_valid_d   = 1'b1;
                        out_rd_w_en_d = is_mem_s ? 1'b0 : in_rd_w_en;
                        out_mis_d     = is_mem_s;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (mem_req_ready) begin
                    req_valid_d = 1'b0;
                    state_d     = S_WAIT;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_WAIT: begin
                if (mem_resp_valid) begin
                    state_d       = S_IDLE;
                    out_valid_d   = 1'b1;
                    out_mis_d     = 1'b0;
                    out_rd_w_en_d = store_q ? 1'b0 : out_rd_w_en_q;
                    out_lsu_d     = store_q ? 64'd0
                                            : load_ext(mem_resp_rdata, out_exu_q[2:0], f3_q);
                end else begin
                    state_d = S_WAIT;
                end
            end
            default: begin
                state_d     = S_IDLE;
                req_valid_d = 1'b0;
            end
        endcase
    end

    // State and all registered outputs; reset abandons any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            f3_q          <= 3'd0;
            store_q       <= 1'b0;
            req_valid_q   <= 1'b0;
            req_addr_q    <= 32'd0;
            req_wen_q     <= 1'b0;
            req_wdata_q   <= 64'd0;
            req_wmask_q   <= 8'd0;
            out_valid_q   <= 1'b0;
            out_pc_q      <= 32'd0;
            out_inst_q    <= 32'd0;
            out_rd_q      <= 5'd0;
            out_rd_w_en_q <= 1'b0;
            out_exu_q     <= 64'd0;
            out_lsu_q     <= 64'd0;
            out_mis_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            f3_q          <= f3_d;
            store_q       <= store_d;
            req_valid_q   <= req_valid_d;
            req_addr_q    <= req_addr_d;
            req_wen_q     <= req_wen_d;
            req_wdata_q   <= req_wdata_d;
            req_wmask_q   <= req_wmask_d;
            out_valid_q   <= out_valid_d;
            out_pc_q      <= out_pc_d;
            out_inst_q    <= out_inst_d;
            out_rd_q      <= out_rd_d;
            out_rd_w_en_q <= out_rd_w_en_d;
            out_exu_q     <= out_exu_d;
            out_lsu_q     <= out_lsu_d;
            out_mis_q     <= out_mis_d;
        end
    end

    assign mem_req_valid  = req_valid_q;
    assign mem_req_addr   = req_addr_q;
    assign mem_req_wen    = req_wen_q;
    assign mem_req_wdata  = req_wdata_q;
    assign mem_req_wmask  = req_wmask_q;
    assign out_valid      = out_valid_q;
    assign out_pc         = out_pc_q;
    assign out_inst       = out_inst_q;
    assign out_rd         = out_rd_q;
    assign out_rd_w_en    = out_rd_w_en_q;
    assign out_exu_result = out_exu_q;
    assign out_lsu_r_data = out_lsu_q;
    assign out_misalign   = out_mis_q;

endmodule

// File: tb/tb_mem_lsu_stage.sv
// Bench for mem_lsu_stage: directed vector table, randomized ops against a byte-level
// reference model, and hand sequences for backpressure and reset during an access.
module tb_mem_lsu_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_ready;
    logic [31:0] in_pc = 32'd0, in_inst = 32'd0;
    logic [4:0]  in_rd = 5'd0;
    logic        in_rd_w_en = 1'b0;
    logic [63:0] in_exu_result = 64'd0, in_x_rs2 = 64'd0;
    logic        in_mem_r_en = 1'b0, in_mem_w_en = 1'b0;
    logic [2:0]  in_funct3 = 3'd0;
    logic        mem_req_valid, mem_req_ready = 1'b0, mem_req_wen;
    logic [31:0] mem_req_addr;
    logic [63:0] mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_resp_valid = 1'b0;
    logic [63:0] mem_resp_rdata = 64'd0;
    logic        out_valid, out_ready = 1'b0, out_rd_w_en, out_misalign;
    logic [31:0] out_pc, out_inst;
    logic [4:0]  out_rd;
    logic [63:0] out_exu_result, out_lsu_r_data;

    int tests = 0;
    int fails = 0;

    mem_lsu_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
        .in_rd(in_rd), .in_rd_w_en(in_rd_w_en), .in_exu_result(in_exu_result),
        .in_x_rs2(in_x_rs2), .in_mem_r_en(in_mem_r_en), .in_mem_w_en(in_mem_w_en),
        .in_funct3(in_funct3),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
        .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
        .out_rd(out_rd), .out_rd_w_en(out_rd_w_en), .out_exu_result(out_exu_result),
        .out_lsu_r_data(out_lsu_r_data), .out_misalign(out_misalign)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  f3;
        logic        r_en;
        logic        w_en;
        logic        rd_w_en;
        logic [63:0] exu;
        logic [63:0] rs2;
        logic [63:0] rdata;
        logic        e_req;
        logic        e_mis;
        logic        e_rdw;
        logic [63:0] e_lsu;
        logic [63:0] e_wdata;
        logic [7:0]  e_wmask;
    } vec_t;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference: access of 2**f3[1:0] bytes at byte offset exu%8 inside an 8-byte word.
    function automatic vec_t model(input logic [2:0] f3, input logic r, input logic w,
                                   input logic rdw, input logic [63:0] exu,
                                   input logic [63:0] rs2, input logic [63:0] rdata);
        vec_t v;
        int bytes, off;
        logic [63:0] mask, val;
        logic mem, mis;
        bytes = 1 << f3[1:0];
        off   = int'(exu % 64'd8);
        mem   = r || w;
        mis   = mem && ((off % bytes) != 0);
        mask  = (bytes == 8) ? {64{1'b1}} : ((64'd1 << (8 * bytes)) - 64'd1);
        val   = (rdata >> (8 * off)) & mask;
        if (!f3[2] && bytes < 8 && val[8 * bytes - 1]) val = val | ~mask;
        v.f3 = f3; v.r_en = r; v.w_en = w; v.rd_w_en = rdw;
        v.exu = exu; v.rs2 = rs2; v.rdata = rdata;
        v.e_req   = mem && !mis;
        v.e_mis   = mis;
        v.e_rdw   = (mem && (w || mis)) ? 1'b0 : rdw;
        v.e_lsu   = (mem && !w && !mis) ? val : 64'd0;
        v.e_wdata = rs2 << (8 * off);
        v.e_wmask = 8'(((1 << bytes) - 1) << off);
        return v;
    endfunction

    // Drive one op, play the memory with the given delays, then drain it after a stall.
    task automatic run_op(input vec_t v, input int rq_wait, input int rs_wait, input int stall);
        logic [31:0] pc, inst;
        logic [4:0]  rd;
        pc = $urandom; inst = $urandom; rd = 5'($urandom);
        @(negedge clk);
        check("in_ready_idle", in_ready, 1);
        in_valid = 1'b1; in_pc = pc; in_inst = inst; in_rd = rd; in_rd_w_en = v.rd_w_en;
        in_exu_result = v.exu; in_x_rs2 = v.rs2; in_mem_r_en = v.r_en;
        in_mem_w_en = v.w_en; in_funct3 = v.f3;
        @(negedge clk);
        in_valid = 1'b0;
        check("req_valid", mem_req_valid, v.e_req);
        if (v.e_req) begin
            check("req_addr", mem_req_addr, v.exu[31:0] & 32'hFFFF_FFF8);
            check("req_wen", mem_req_wen, v.w_en);
            if (v.w_en) begin
                check("req_wdata", mem_req_wdata, v.e_wdata);
                check("req_wmask", mem_req_wmask, v.e_wmask);
            end
            for (int i = 0; i < rq_wait; i++) begin
                mem_resp_valid = 1'($urandom);
                mem_resp_rdata = {$urandom, $urandom};
                @(negedge clk);
                check("req_hold", mem_req_valid, 1);
                check("req_addr_hold", mem_req_addr, v.exu[31:0] & 32'hFFFF_FFF8);
                check("out_valid_req", out_valid, 0);
            end
            mem_resp_valid = 1'b0;
            mem_req_ready  = 1'b1;
            @(negedge clk);
            mem_req_ready = 1'b0;
            check("wait_no_req", mem_req_valid, 0);
            for (int i = 0; i < rs_wait; i++) begin
                @(negedge clk);
                check("out_valid_wait", out_valid, 0);
            end
            mem_resp_valid = 1'b1;
            mem_resp_rdata = v.rdata;
            @(negedge clk);
            mem_resp_valid = 1'b0;
        end
        check("out_valid", out_valid, 1);
        check("out_pc", out_pc, pc);
        check("out_inst", out_inst, inst);
        check("out_rd", out_rd, rd);
        check("out_exu", out_exu_result, v.exu);
        check("out_rd_w_en", out_rd_w_en, v.e_rdw);
        check("out_lsu", out_lsu_r_data, v.e_lsu);
        check("out_misalign", out_misalign, v.e_mis);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall_valid", out_valid, 1);
            check("stall_lsu", out_lsu_r_data, v.e_lsu);
            check("stall_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("drained", out_valid, 0);
    endtask

    vec_t tbl [17];

    initial begin
        vec_t v;
        logic [2:0] f3, am;
        int kind;
        logic [63:0] exu;

        tbl[0]  = '{3'b000, 1'b0, 1'b0, 1'b1, 64'h1234, 64'd0, 64'd0,
                    1'b0, 1'b0, 1'b1, 64'd0, 64'd0, 8'd0};
        tbl[1]  = '{3'b000, 1'b1, 1'b0, 1'b1, 64'h8000_0003, 64'd0, 64'h0000_0000_8000_0000,
                    1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FF80, 64'd0, 8'd0};
        tbl[2]  = '{3'b001, 1'b0, 1'b1, 1'b1, 64'h8000_0006, 64'hABCD, 64'd0,
                    1'b1, 1'b0, 1'b0, 64'd0, 64'hABCD_0000_0000_0000, 8'hC0};
        tbl[3]  = '{3'b010, 1'b1, 1'b0, 1'b1, 64'h8000_0002, 64'd0, 64'd0,
                    1'b0, 1'b1, 1'b0, 64'd0, 64'd0, 8'd0};
        tbl[4]  = '{3'b011, 1'b1, 1'b0, 1'b1, 64'h8000_0008, 64'd0, 64'h0123_4567_89AB_CDEF,
                    1'b1, 1'b0, 1'b1, 64'h0123_4567_89AB_CDEF, 64'd0, 8'd0};
        tbl[5]  = '{3'b100, 1'b1, 1'b0, 1'b1, 64'h8000_0005, 64'd0, 64'h0000_8A00_0000_0000,
                    1'b1, 1'b0, 1'b1, 64'h8A, 64'd0, 8'd0};
        tbl[6]  = '{3'b101, 1'b1, 1'b0, 1'b1, 64'h8000_0002, 64'd0, 64'h0000_0000_F00D_0000,
                    1'b1, 1'b0, 1'b1, 64'hF00D, 64'd0, 8'd0};
        tbl[7]  = '{3'b001, 1'b1, 1'b0, 1'b1, 64'h8000_0002, 64'd0, 64'h0000_0000_F00D_0000,
                    1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_F00D, 64'd0, 8'd0};
        tbl[8]  = '{3'b110, 1'b1, 1'b0, 1'b1, 64'h8000_0004, 64'd0, 64'h89AB_CDEF_0000_0000,
                    1'b1, 1'b0, 1'b1, 64'h89AB_CDEF, 64'd0, 8'd0};
        tbl[9]  = '{3'b010, 1'b1, 1'b0, 1'b1, 64'h8000_0004, 64'd0, 64'h89AB_CDEF_0000_0000,
                    1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_89AB_CDEF, 64'd0, 8'd0};
        tbl[10] = '{3'b011, 1'b0, 1'b1, 1'b0, 64'h8000_0010, 64'h1122_3344_5566_7788, 64'd0,
                    1'b1, 1'b0, 1'b0, 64'd0, 64'h1122_3344_5566_7788, 8'hFF};
        tbl[11] = '{3'b000, 1'b0, 1'b1, 1'b0, 64'h8000_0007, 64'h5A, 64'd0,
                    1'b1, 1'b0, 1'b0, 64'd0, 64'h5A00_0000_0000_0000, 8'h80};
        tbl[12] = '{3'b010, 1'b0, 1'b1, 1'b1, 64'h8000_0006, 64'h77, 64'd0,
                    1'b0, 1'b1, 1'b0, 64'd0, 64'd0, 8'd0};
        tbl[13] = '{3'b010, 1'b1, 1'b1, 1'b1, 64'h8000_0004, 64'hDEAD_BEEF, 64'hFFFF_FFFF_FFFF_FFFF,
                    1'b1, 1'b0, 1'b0, 64'd0, 64'hDEAD_BEEF_0000_0000, 8'hF0};
        tbl[14] = '{3'b111, 1'b1, 1'b0, 1'b1, 64'h8000_0000, 64'd0, 64'hFEDC_BA98_7654_3210,
                    1'b1, 1'b0, 1'b1, 64'hFEDC_BA98_7654_3210, 64'd0, 8'd0};
        tbl[15] = '{3'b001, 1'b1, 1'b0, 1'b1, 64'h8000_0001, 64'd0, 64'd0,
                    1'b0, 1'b1, 1'b0, 64'd0, 64'd0, 8'd0};
        tbl[16] = '{3'b010, 1'b0, 1'b0, 1'b0, 64'hFFFF_0000_1234_5677, 64'd0, 64'd0,
                    1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 8'd0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_req_valid", mem_req_valid, 0);
        check("rst_out_exu", out_exu_result, 0);
        check("rst_out_lsu", out_lsu_r_data, 0);
        check("rst_out_rd_w_en", out_rd_w_en, 0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);

        foreach (tbl[i]) run_op(tbl[i], 0, 0, (i % 3));

        // Backpressure for three cycles, then a new op accepted in the same cycle as the drain.
        @(negedge clk);
        in_valid = 1'b1; in_mem_r_en = 1'b0; in_mem_w_en = 1'b0;
        in_exu_result = 64'h1234; in_rd_w_en = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("bp_valid", out_valid, 1);
            check("bp_exu", out_exu_result, 64'h1234);
            check("bp_in_ready", in_ready, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1);
        in_valid = 1'b1; in_exu_result = 64'h5555;
        @(negedge clk);
        in_valid = 1'b0;
        check("b2b_valid", out_valid, 1);
        check("b2b_exu", out_exu_result, 64'h5555);
        @(negedge clk);
        out_ready = 1'b0;
        check("b2b_drained", out_valid, 0);

        // Stray response while idle.
        mem_resp_valid = 1'b1;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        check("idle_resp_ignored", out_valid, 0);

        // Reset while in REQ.
        in_valid = 1'b1; in_mem_r_en = 1'b1; in_funct3 = 3'b011; in_exu_result = 64'h8000_0020;
        @(negedge clk);
        in_valid = 1'b0;
        check("rreq_req", mem_req_valid, 1);
        rst = 1'b1;
        #1;
        check("rreq_req_cleared", mem_req_valid, 0);
        check("rreq_addr_cleared", mem_req_addr, 0);
        @(negedge clk);
        rst = 1'b0;

        // Reset while in WAIT, then a stale response.
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        check("rwait_in_wait", mem_req_valid, 0);
        rst = 1'b1;
        #1;
        check("rwait_out_valid", out_valid, 0);
        check("rwait_out_exu", out_exu_result, 0);
        @(negedge clk);
        rst = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_rdata = 64'h1111_2222_3333_4444;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        check("stale_resp_out_valid", out_valid, 0);
        check("stale_resp_in_ready", in_ready, 1);
        in_mem_r_en = 1'b0;

        for (int n = 0; n < 150; n++) begin
            kind = $urandom_range(0, 3);
            f3   = (kind >= 2) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
            exu  = {$urandom, $urandom};
            am   = (3'b001 << f3[1:0]) - 3'b001;
            if ($urandom_range(0, 3) != 0) exu[2:0] = exu[2:0] & ~am;
            v = model(f3, kind == 1 || kind == 3, kind >= 2, 1'($urandom), exu,
                      {$urandom, $urandom}, {$urandom, $urandom});
            run_op(v, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
